ifu_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC register and the instruction memory bus. Issues one fetch request at a time for the current PC and produces the one-cycle fetch-accept pulse that advances the PC. Holds the returned instruction in a 1-entry output buffer toward decode. Discards in-flight responses made stale by branch, exception or mret redirects.

---
 rtl/ifu_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding bus request, 1-entry output buffer, stale-response drop.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT/DROP watchdog driving timeout_o.
module ifu_fetch_ctrl #(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    input  logic            pipe_stall,
    output logic            fetch_hand_suc,
    output logic            bus_req_o,
    output logic [XLEN-1:0] bus_addr_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [ILEN-1:0] bus_rdata_i,
    input  logic            bus_rerr_i,
    output logic            inst_valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o,
    output logic            timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc_q;
    logic            can_issue;
    logic            buf_wr;
    logic [ILEN-1:0] buf_data;
    logic            buf_flt;
    logic            to_hit;
    logic            tmo_fire;

    always_comb begin
        can_issue      = fetch_en & ~redirect_i & (~inst_valid_o | ~pipe_stall);
        bus_req_o      = rst_n & (state == S_REQ) & can_issue;
        bus_addr_o     = pc_i;
        fetch_hand_suc = bus_req_o & bus_gnt_i;
        state_nxt      = state;
        buf_wr         = 1'b0;
        buf_data       = bus_rdata_i;
        buf_flt        = bus_rerr_i;
        tmo_fire       = 1'b0;
        case (state)
            S_IDLE: if (can_issue) state_nxt = S_REQ;
            S_REQ: begin
                if (fetch_hand_suc) state_nxt = S_WAIT;
                else if (!fetch_en) state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (redirect_i) begin
                    state_nxt = bus_rvalid_i ? S_REQ : S_DROP;
                end else if (bus_rvalid_i) begin
                    buf_wr    = 1'b1;
                    state_nxt = fetch_en ? S_REQ : S_IDLE;
                end else if (to_hit) begin
                    // Timed-out fetch is reported to decode as an access fault
                    buf_wr    = 1'b1;
                    buf_data  = '0;
                    buf_flt   = 1'b1;
                    tmo_fire  = 1'b1;
                    state_nxt = fetch_en ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (bus_rvalid_i) begin
                    state_nxt = fetch_en ? S_REQ : S_IDLE;
                end else if (to_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = fetch_en ? S_REQ : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_hand_suc) pc_q <= pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_fault_o <= 1'b0;
        end else if (redirect_i) begin
            inst_valid_o <= 1'b0;
        end else if (buf_wr) begin
            inst_valid_o <= 1'b1;
            inst_o       <= buf_data;
            inst_pc_o    <= pc_q;
            inst_fault_o <= buf_flt;
        end else if (inst_valid_o && !pipe_stall) begin
            inst_valid_o <= 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tcnt;

    // Counter restarts on every state change, so it measures time spent in the current WAIT/DROP visit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt      <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= tmo_fire;
            if (state_nxt != state) tcnt <= '0;
            else if (state == S_WAIT || state == S_DROP) tcnt <= tcnt + 1'b1;
        end
    end

    assign to_hit = (tcnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;

    assign to_hit     = 1'b0;
    assign timeout_o  = 1'b0;
    assign unused_tmo = tmo_fire ^ (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Table-driven bench for ifu_fetch_ctrl; the timeout sequence follows the FETCH_TIMEOUT_EN setting.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] pc_i;
    logic        redirect_i;
    logic        pipe_stall;
    logic        fetch_hand_suc;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_rerr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    ifu_fetch_ctrl #(
        .XLEN(32),
        .ILEN(32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .pc_i(pc_i),
        .redirect_i(redirect_i),
        .pipe_stall(pipe_stall),
        .fetch_hand_suc(fetch_hand_suc),
        .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o),
        .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i),
        .bus_rerr_i(bus_rerr_i),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .inst_pc_o(inst_pc_o),
        .inst_fault_o(inst_fault_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, en, rd, st, gnt, rv, err;
        logic [31:0] pc, data;
        logic        e_req, e_hand, e_val, e_flt, e_to;
        logic [31:0] e_inst, e_ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, en, input logic [31:0] pc,
                                input logic rd, st, gnt, rv, input logic [31:0] d, input logic er,
                                input logic q, h, val, input logic [31:0] ins, ipc, input logic f);
        vec_t t;
        t.rst_n = r;   t.en = en;   t.pc = pc;     t.rd = rd;  t.st = st;
        t.gnt = gnt;   t.rv = rv;   t.data = d;    t.err = er;
        t.e_req = q;   t.e_hand = h; t.e_val = val; t.e_inst = ins; t.e_ipc = ipc;
        t.e_flt = f;   t.e_to = 1'b0;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst_n = t.rst_n;  fetch_en = t.en;  pc_i = t.pc;  redirect_i = t.rd;
        pipe_stall = t.st; bus_gnt_i = t.gnt; bus_rvalid_i = t.rv;
        bus_rdata_i = t.data; bus_rerr_i = t.err;
        #1;
        chk($sformatf("v%0d bus_req_o", idx), {31'b0, bus_req_o}, {31'b0, t.e_req});
        chk($sformatf("v%0d fetch_hand_suc", idx), {31'b0, fetch_hand_suc}, {31'b0, t.e_hand});
        if (t.e_req) chk($sformatf("v%0d bus_addr_o", idx), bus_addr_o, t.pc);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d inst_valid_o", idx), {31'b0, inst_valid_o}, {31'b0, t.e_val});
        chk($sformatf("v%0d timeout_o", idx), {31'b0, timeout_o}, {31'b0, t.e_to});
        if (t.e_val || !t.rst_n) begin
            chk($sformatf("v%0d inst_o", idx), inst_o, t.e_inst);
            chk($sformatf("v%0d inst_pc_o", idx), inst_pc_o, t.e_ipc);
            chk($sformatf("v%0d inst_fault_o", idx), {31'b0, inst_fault_o}, {31'b0, t.e_flt});
        end
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0; fetch_en = 1'b0; pc_i = '0; redirect_i = 1'b0; pipe_stall = 1'b0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_rerr_i = 1'b0;

        //            rst en pc            rd st gnt rv data          er   req hnd val inst          ipc           flt
        vecs.push_back(mk(0, 1, 32'h80000000, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h80000000, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000000, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000000, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000004, 0, 0, 0, 1, 32'h00000013, 0,   0, 0, 1, 32'h00000013, 32'h80000000, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, 32'h80000004, 0, 1, 0, 0, 32'h0,    0,   0, 0, 1, 32'h00000013, 32'h80000000, 0));
        vecs.push_back(mk(1, 1, 32'h80000004, 0, 0, 0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000004, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000008, 0, 0, 1, 1, 32'h00000093, 0,   0, 0, 1, 32'h00000093, 32'h80000004, 0));
        vecs.push_back(mk(1, 1, 32'h80000008, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,        32'h0,        0));
        // redirect in WAIT, stale response three cycles later must not reach decode
        vecs.push_back(mk(1, 1, 32'h80000008, 1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000010, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000010, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000010, 0, 0, 1, 1, 32'hDEADBEEF, 0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000010, 0, 0, 0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000010, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000014, 0, 0, 0, 1, 32'h0BADC0DE, 1,   0, 0, 1, 32'h0BADC0DE, 32'h80000010, 1));
        vecs.push_back(mk(1, 1, 32'h80000014, 0, 1, 0, 0, 32'h0,        0,   0, 0, 1, 32'h0BADC0DE, 32'h80000010, 1));
        // redirect coincident with grant: no handshake, buffer flushed
        vecs.push_back(mk(1, 1, 32'h80000014, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000200, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h80000200, 0, 0, 0, 1, 32'h22222222, 0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000200, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000200, 0, 0, 0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h80000200, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h80000200, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000300, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h80000300, 0, 0, 0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Unanswered fetch: watchdog fault entry when enabled, otherwise an indefinite wait
        apply(mk(1, 1, 32'h80000300, 0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0, 0), 100);
        for (int i = 0; i < 3; i++)
            apply(mk(1, 1, 32'h80000304, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0), 101 + i);
`ifdef FETCH_TIMEOUT_EN
        t = mk(1, 1, 32'h80000304, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0, 32'h80000300, 1);
        t.e_to = 1'b1;
        apply(t, 104);
        apply(mk(1, 1, 32'h80000304, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 0), 105);
`else
        t = mk(1, 1, 32'h80000304, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        apply(t, 104);
        apply(mk(1, 1, 32'h80000304, 0, 0, 0, 1, 32'h33333333, 0, 0, 0, 1, 32'h33333333, 32'h80000300, 0), 105);
        apply(mk(1, 1, 32'h80000304, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 0), 106);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
